// File: rtl/smi_pkg.sv
// Shared definitions for smi_channel_bridge: default sizes, read FSM state type
// and status word layout (status reads exist only with SMI_BRIDGE_STATUS_EN).
package smi_pkg;

  localparam int SMI_DATA_WIDTH = 8;
  localparam int SMI_ADDR_WIDTH = 2;
  localparam int SMI_FIFO_DEPTH = 16;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRIVE = 1'b1
  } rd_state_t;

  // Status word, LSB first: RX free count, TX level, tx_underrun, rx_overflow.
  // Both count fields are lvl_w bits wide.
  localparam int STAT_RX_FREE_LSB = 0;

  function automatic int stat_tx_level_lsb(input int lvl_w);
    return lvl_w;
  endfunction

  function automatic int stat_underrun_bit(input int lvl_w);
    return 2 * lvl_w;
  endfunction

  function automatic int stat_overflow_bit(input int lvl_w);
    return 2 * lvl_w + 1;
  endfunction

  function automatic int stat_width(input int lvl_w);
    return 2 * lvl_w + 2;
  endfunction

endpackage

// File: rtl/smi_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; a pop frees a slot for a
// same-cycle push even when full.
module smi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level    = wr_ptr - rd_ptr;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/smi_channel_bridge.sv
// Raspberry Pi SMI slave bridging Pi writes to an RX stream and a TX stream to
// Pi reads. Defining SMI_BRIDGE_STATUS_EN makes reads at the all-ones address return status.
module smi_channel_bridge
  import smi_pkg::*;
#(
  parameter int DATA_WIDTH = SMI_DATA_WIDTH,
  parameter int ADDR_WIDTH = SMI_ADDR_WIDTH,
  parameter int FIFO_DEPTH = SMI_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  inout  wire  [DATA_WIDTH-1:0] smi_data,
  input  logic [ADDR_WIDTH-1:0] smi_addr,
  input  logic                  smi_oe_n,
  input  logic                  smi_we_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [ADDR_WIDTH-1:0] rx_chan,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  input  logic                  err_clear
);

  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int STAT_W    = stat_width(LVL_W);
  localparam int STAT_KEEP = (STAT_W < DATA_WIDTH) ? STAT_W : DATA_WIDTH;
  localparam int TXL_LSB   = stat_tx_level_lsb(LVL_W);
  localparam int UND_BIT   = stat_underrun_bit(LVL_W);
  localparam int OVF_BIT   = stat_overflow_bit(LVL_W);
  localparam int RXW       = ADDR_WIDTH + DATA_WIDTH;

  logic [1:0]            oe_sync;
  logic [1:0]            we_sync;
  logic [ADDR_WIDTH-1:0] addr_s1, addr_s2;
  logic [DATA_WIDTH-1:0] data_s1, data_s2;
  logic                  oe_prev, we_prev;
  logic [1:0]            settle_cnt;
  logic                  run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_sync    <= 2'b11;
      we_sync    <= 2'b11;
      oe_prev    <= 1'b1;
      we_prev    <= 1'b1;
      addr_s1    <= '0;
      addr_s2    <= '0;
      data_s1    <= '0;
      data_s2    <= '0;
      settle_cnt <= 2'd3;
      run        <= 1'b0;
    end else begin
      oe_sync <= {oe_sync[0], smi_oe_n};
      we_sync <= {we_sync[0], smi_we_n};
      oe_prev <= oe_sync[1];
      we_prev <= we_sync[1];
      addr_s1 <= smi_addr;
      addr_s2 <= addr_s1;
      data_s1 <= smi_data;
      data_s2 <= data_s1;
      run     <= 1'b1;
      if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
    end
  end

  // Edges are ignored until the reset-preset stages have filled with real pin
  // values, so a strobe held low across reset is not mistaken for a new one.
  logic edge_ok, wr_strobe, rd_start, rd_end;
  assign edge_ok   = (settle_cnt == 2'd0);
  assign wr_strobe = edge_ok && we_prev && !we_sync[1] && oe_sync[1];
  assign rd_start  = edge_ok && oe_prev && !oe_sync[1];
  assign rd_end    = !oe_prev && oe_sync[1];

  logic [RXW-1:0]        rx_head;
  logic                  rx_full, rx_empty, rx_pop;
  logic [LVL_W-1:0]      rx_level;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [LVL_W-1:0]      tx_level;

  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_empty ? '0 : rx_head[DATA_WIDTH-1:0];
  assign rx_chan  = rx_empty ? '0 : rx_head[DATA_WIDTH +: ADDR_WIDTH];
  assign tx_ready = run && !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  smi_sync_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_strobe),
    .push_data ({addr_s2, data_s2}),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  smi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  logic [LVL_W-1:0]      rx_free;
  logic [STAT_W-1:0]     status_vec;
  logic [DATA_WIDTH-1:0] status_word;
  logic                  unused_stat_bits;
  logic                  is_status;

  assign rx_free = LVL_W'(FIFO_DEPTH) - rx_level;

  always_comb begin
    status_vec                                = '0;
    status_vec[STAT_RX_FREE_LSB +: LVL_W]     = rx_free;
    status_vec[TXL_LSB +: LVL_W]              = tx_level;
    status_vec[UND_BIT]                       = tx_underrun;
    status_vec[OVF_BIT]                       = rx_overflow;
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_KEEP-1:0] = status_vec[STAT_KEEP-1:0];
  end

  assign unused_stat_bits = ^status_vec;

`ifdef SMI_BRIDGE_STATUS_EN
  assign is_status = &addr_s2;
`else
  assign is_status = 1'b0;
`endif

  rd_state_t             state, next_state;
  logic                  rd_load;
  logic                  rd_has_word;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RD_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_load    = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      RD_IDLE: begin
        if (rd_start) begin
          next_state = RD_DRIVE;
          rd_load    = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (rd_end) begin
          next_state = RD_IDLE;
          tx_pop     = rd_has_word;
        end
      end
      default: next_state = RD_IDLE;
    endcase
  end

  // rd_has_word marks a read that presented a real TX entry; only such a read pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_word     <= '0;
      rd_has_word <= 1'b0;
    end else if (rd_load) begin
      if (is_status) begin
        rd_word     <= status_word;
        rd_has_word <= 1'b0;
      end else if (tx_empty) begin
        rd_word     <= '0;
        rd_has_word <= 1'b0;
      end else begin
        rd_word     <= tx_head;
        rd_has_word <= 1'b1;
      end
    end
  end

  assign smi_data = (state == RD_DRIVE) ? rd_word : 'z;

  logic ovf_set, und_set;
  assign ovf_set = wr_strobe && rx_full && !rx_pop;
  assign und_set = rd_load && !is_status && tx_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (err_clear) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (ovf_set) rx_overflow <= 1'b1;
      if (und_set) tx_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smi_channel_bridge.sv
// Scoreboard bench for smi_channel_bridge: queue-based reference model, with
// separate monitors for the RX stream and for Pi bus reads.
`timescale 1ns/1ps
module tb_smi_channel_bridge;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 16;
`ifdef SMI_BRIDGE_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  tri   [DW-1:0] smi_data;
  logic [DW-1:0] pi_data = '0;
  logic          pi_drive = 1'b0;
  logic [AW-1:0] smi_addr = '0;
  logic          smi_oe_n = 1'b1;
  logic          smi_we_n = 1'b1;
  logic [DW-1:0] rx_data;
  logic [AW-1:0] rx_chan;
  logic          rx_valid;
  wire           rx_ready;
  logic          rx_ready_dir = 1'b0;
  logic          rand_rx = 1'b0;
  logic          rnd_bit = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          rx_overflow, tx_underrun;
  logic          err_clear = 1'b0;

  assign smi_data = pi_drive ? pi_data : 'z;
  assign rx_ready = rx_ready_dir | (rand_rx & rnd_bit);

  always #5 clk = ~clk;

  smi_channel_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .smi_data    (smi_data),
    .smi_addr    (smi_addr),
    .smi_oe_n    (smi_oe_n),
    .smi_we_n    (smi_we_n),
    .rx_data     (rx_data),
    .rx_chan     (rx_chan),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_overflow (rx_overflow),
    .tx_underrun (tx_underrun),
    .err_clear   (err_clear)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] rx_exp[$];
  logic [DW-1:0]    rd_exp[$];
  logic [DW-1:0]    tx_model[$];
  bit               m_ovf = 1'b0;
  bit               m_und = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] status_model();
    int lw = $clog2(DEPTH) + 1;
    int v;
    v = (int'(m_ovf) << (2*lw + 1)) | (int'(m_und) << (2*lw)) |
        (tx_model.size() << lw) | (DEPTH - rx_exp.size());
    return v[DW-1:0];
  endfunction

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  initial begin : rx_mon
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) check("rx_unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
        else begin
          e = rx_exp.pop_front();
          check("rx_chan", 32'(rx_chan), 32'(e[DW +: AW]));
          check("rx_data", 32'(rx_data), 32'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin : bus_mon
    int cnt = 0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (smi_oe_n) cnt = 0;
      else begin
        cnt++;
        if (cnt == 5) begin
          if (rd_exp.size() == 0) check("rd_unexpected", 32'(smi_data), 32'hFFFF_FFFF);
          else begin
            e = rd_exp.pop_front();
            check("rd_data", 32'(smi_data), 32'(e));
          end
        end
      end
    end
  end

  task automatic pi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit chk_lat, input bit pop_pulse);
    @(posedge clk); #1 smi_addr = a; pi_data = d; pi_drive = 1'b1;
    @(posedge clk); #1 smi_we_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (chk_lat) check("rx_valid_before_latency", 32'(rx_valid), 32'd0);
    if (pop_pulse) rx_ready_dir = 1'b1;
    @(posedge clk); #1;
    if (pop_pulse) rx_ready_dir = 1'b0;
    if (rx_exp.size() < DEPTH) rx_exp.push_back({a, d});
    else m_ovf = 1'b1;
    if (chk_lat) check("rx_valid_at_latency", 32'(rx_valid), 32'd1);
    @(posedge clk); #1 smi_we_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 pi_drive = 1'b0;
  endtask

  task automatic pi_read(input logic [AW-1:0] a);
    @(posedge clk); #1 smi_addr = a;
    if (STATUS_EN && (a == '1)) rd_exp.push_back(status_model());
    else if (tx_model.size() == 0) begin
      rd_exp.push_back('0);
      m_und = 1'b1;
    end else rd_exp.push_back(tx_model.pop_front());
    @(posedge clk); #1 smi_oe_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 smi_oe_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [DW-1:0] d);
    int n = 0;
    @(posedge clk); #1 tx_data = d; tx_valid = 1'b1;
    while (!tx_ready && n < 50) begin
      @(posedge clk); #1 n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    @(posedge clk); #1 tx_valid = 1'b0;
    tx_model.push_back(d);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    m_ovf = 1'b0;
    m_und = 1'b0;
  endtask

  task automatic wait_rx_drain();
    int n = 0;
    while (rx_exp.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    check("rx_words_left", 32'(rx_exp.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
    check({tag, "_tx_ready"},    32'(tx_ready),    32'd0);
    check({tag, "_rx_data"},     32'(rx_data),     32'd0);
    check({tag, "_rx_chan"},     32'(rx_chan),     32'd0);
    check({tag, "_rx_overflow"}, 32'(rx_overflow), 32'd0);
    check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("tx_ready_after_reset", 32'(tx_ready), 32'd1);

    // three writes to channel 1, first one timed
    rx_ready_dir = 1'b1;
    pi_write(2'd1, 8'h11, 1'b1, 1'b0);
    pi_write(2'd1, 8'h22, 1'b0, 1'b0);
    pi_write(2'd1, 8'h33, 1'b0, 1'b0);
    wait_rx_drain();
    rx_ready_dir = 1'b0;

    // two TX words then an underrun read
    tx_push(8'hA5);
    tx_push(8'h5A);
    pi_read(2'd0);
    pi_read(2'd0);
    pi_read(2'd0);
    check("tx_underrun_set", 32'(tx_underrun), 32'd1);
    pulse_clear();
    check("tx_underrun_cleared", 32'(tx_underrun), 32'd0);

    // all-ones address read: status or plain data depending on build
    tx_push(8'h3C);
    tx_push(8'hC3);
    pi_read(2'd3);
    pi_read(2'd0);
    pi_read(2'd0);
    check("tx_underrun_after_status", 32'(tx_underrun), 32'(m_und));

    // overflow: 17 writes with no consumer
    for (int i = 0; i < 17; i++)
      pi_write(AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("rx_overflow_set", 32'(rx_overflow), 32'd1);
    check("rx_valid_full", 32'(rx_valid), 32'd1);
    pi_read(2'd3);
    pulse_clear();
    check("rx_overflow_cleared", 32'(rx_overflow), 32'd0);
    check("tx_underrun_cleared2", 32'(tx_underrun), 32'd0);

    // write into a full FIFO in the same cycle as a pop
    pi_write(2'd2, 8'h5C, 1'b0, 1'b1);
    check("rx_overflow_full_pop", 32'(rx_overflow), 32'd0);
    rx_ready_dir = 1'b1;
    wait_rx_drain();
    rx_ready_dir = 1'b0;
    check("rx_valid_drained", 32'(rx_valid), 32'd0);

    // randomized mix with a random consumer
    rand_rx = 1'b1;
    wcount = 0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: if (wcount < 10) begin
             pi_write(AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), 1'b0, 1'b0);
             wcount++;
           end
        1: if (tx_model.size() < 12) tx_push(DW'($urandom_range(0, 255)));
        default: pi_read(AW'($urandom_range(0, 2)));
      endcase
    end
    rand_rx = 1'b0;
    rx_ready_dir = 1'b1;
    wait_rx_drain();
    rx_ready_dir = 1'b0;
    check("rx_overflow_random", 32'(rx_overflow), 32'd0);
    check("tx_underrun_random", 32'(tx_underrun), 32'(m_und));
    pulse_clear();
    while (tx_model.size() > 0) pi_read(2'd0);

    // reset in the middle of a driven read
    tx_push(8'h77);
    @(posedge clk); #1 smi_addr = 2'd0;
    rd_exp.push_back(tx_model.pop_front());
    @(posedge clk); #1 smi_oe_n = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    pi_data = 8'h00;
    pi_drive = 1'b1;
    tx_model.delete();
    rx_exp.delete();
    m_ovf = 1'b0;
    m_und = 1'b0;
    #1 check("bus_released_in_reset", 32'(smi_data), 32'd0);
    check_reset_outputs("midread");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("no_resume_bus", 32'(smi_data), 32'd0);
    check("no_resume_underrun", 32'(tx_underrun), 32'd0);
    pi_drive = 1'b0;
    smi_oe_n = 1'b1;
    repeat (5) @(posedge clk);

    // normal operation after reset
    tx_push(8'h96);
    pi_read(2'd0);
    check("rd_words_left", 32'(rd_exp.size()), 32'd0);
    check("tx_underrun_final", 32'(tx_underrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
